rr_arbiter4: RTL
================

Name: rr_arbiter4

Overview:
- Round-robin arbiter that shares one downstream resource among 4 requesters.
- Each cycle the combinational core turns the 4-bit request vector into a one-hot grant plus a 2-bit encoded owner index, using the same 4-to-2 encoding as the lab encoder.
- Adds fairness (rotating priority pointer), grant hold/lock and a maximum-hold timeout.
- Sits between requesting blocks and the shared datapath; gnt_idx drives the resource's input mux select.

Parameters:
- N, 4, number of requesters; the block supports exactly 4.
- IDX_W, 2, width of the encoded index; fixed at 2 for N=4.
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the grant; legal range 2..255.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  4  request vector; req[i]=1 means requester i wants the resource.
- done  in  1  current owner finished; sampled only while gnt_vld=1.
- gnt  out  4  one-hot grant, registered; 0000 when no owner.
- gnt_idx  out  2  encoded owner index, registered; 0 when gnt_vld=0.
- gnt_vld  out  1  a grant is active, registered.

Behaviour:
- Reset (async, immediate, valid mid-operation): state=IDLE, gnt=0000, gnt_idx=0, gnt_vld=0, ptr=0, hold_cnt=0.
- Internal state:
  - 2-bit ptr: highest-priority requester for the next arbitration.
  - hold_cnt: 8-bit counter.
  - FSM with states IDLE and BUSY.
- Pick function: search req in order ptr, ptr+1, ptr+2, ptr+3 (mod 4, wrapping 3 to 0); the first set bit wins.
- IDLE:
  - req=0000: stay IDLE, outputs 0.
  - Any req bit set: next edge goes to BUSY with gnt=onehot(winner), gnt_idx=winner, gnt_vld=1, hold_cnt=0.
  - Latency: request sampled at edge k gives grant visible after edge k+1 (one cycle).
- BUSY, release condition, evaluated each cycle:
  - done=1, or
  - req[owner]=0, or
  - hold_cnt == MAX_HOLD-1.
- BUSY, no release: hold the grant, hold_cnt increments by 1; req changes on non-owners are ignored.
- BUSY, release: next edge sets state=IDLE, gnt=0000, gnt_idx=0, gnt_vld=0, ptr=(owner+1) mod 4 (wraps 3 to 0), hold_cnt=0.
- Mandatory one-cycle bubble between owners: gnt_vld is low for at least 1 cycle; the next grant follows one cycle after IDLE.
- Grant duration: an owner holds for at most MAX_HOLD cycles (hold_cnt runs 0..MAX_HOLD-1).
- Simultaneous release causes (done plus timeout, or done plus req drop): a single release with identical behaviour.
- done while gnt_vld=0 has no effect.
- Starvation bound: any continuously asserted requester is granted within 3*(MAX_HOLD+1)+1 cycles.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_vld == |gnt.
  - gnt_idx == encode(gnt).
- Outputs are registered; there is no combinational path from req or done to any output.

Decomposition:
- Package arb_pkg holds:
  - localparams N=4, IDX_W=2;
  - state encodings ST_IDLE=1'b0, ST_BUSY=1'b1;
  - HOLD_W=8.
- One combinational sub-module, rr_pick4:
  - inputs req[3:0], ptr[1:0];
  - outputs win_idx[1:0], win_vld;
  - implementation: rotate req right by ptr, priority-encode lowest set bit (4-to-2), add ptr mod 4.
- rr_arbiter4 holds the FSM, ptr, hold_cnt and output registers.

Test Plan:
1. Reset, then req=0001 -> one cycle later gnt=0001, gnt_idx=0, gnt_vld=1; drop req -> one cycle later gnt=0000, gnt_vld=0, ptr=1.
2. req=1111 held, done pulsed on each owner's 2nd grant cycle -> owners in order 0,1,2,3,0, with exactly one gnt_vld=0 cycle between grants.
3. From reset req=1010 held, done pulses -> gnt_idx sequence 1,3,1,3; requesters 0 and 2 are never granted.
4. MAX_HOLD=8, req=0011 constant, done=0 -> owner 0 holds exactly 8 cycles, 1 bubble, owner 1 holds 8 cycles, 1 bubble, owner 0 again.
5. Owner 2 granted; req[2] drops while req=1011 -> next cycle gnt=0, ptr=3; following cycle gnt_idx=3.
6. Async rst asserted mid-BUSY between clock edges -> gnt=0000, gnt_idx=0, gnt_vld=0 immediately; after deassert with req=1000 -> gnt_idx=3 one cycle later, and the first grant comes from ptr=0 order.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants and types for the 4-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned N      = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned HOLD_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set request at or after ptr (mod 4).
module rr_pick4
  import arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_vld
);

  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;

  // Rotate right by ptr so the highest-priority requester lands at bit 0.
  always_comb begin
    rot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      rot[i] = req[IDX_W'(i + ptr)];
    end
  end

  // Lowest set bit of the rotated vector, 4-to-2 encoded.
  always_comb begin
    priority casez (rot)
      4'b???1: off = 2'd0;
      4'b??10: off = 2'd1;
      4'b?100: off = 2'd2;
      4'b1000: off = 2'd3;
      default: off = 2'd0;
    endcase
  end

  // Undo the rotation; 2-bit add wraps 3 to 0 naturally.
  always_comb begin
    win_idx = off + ptr;
    win_vld = |req;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for 4 requesters with grant hold, done release and max-hold timeout.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  state_t              state;
  state_t              state_nxt;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    ptr_nxt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [HOLD_W-1:0]   hold_nxt;
  logic [N-1:0]        gnt_nxt;
  logic [IDX_W-1:0]    idx_nxt;
  logic                vld_nxt;
  logic [IDX_W-1:0]    win_idx;
  logic                win_vld;
  logic                release_now;

  rr_pick4 u_pick (
    .req     (req),
    .ptr     (ptr),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

  // The registered gnt_idx is the current owner, so the release test needs no extra state.
  always_comb begin
    release_now = done || !req[gnt_idx] || (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, priority pointer and hold counter.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    case (state)
      ST_IDLE: begin
        hold_nxt = '0;
        if (win_vld) begin
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (release_now) begin
          state_nxt = ST_IDLE;
          ptr_nxt   = gnt_idx + 2'd1;
          hold_nxt  = '0;
        end else begin
          hold_nxt  = hold_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered grant outputs.
  always_comb begin
    gnt_nxt = '0;
    idx_nxt = '0;
    vld_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (win_vld) begin
          gnt_nxt = 4'b0001 << win_idx;
          idx_nxt = win_idx;
          vld_nxt = 1'b1;
        end
      end
      ST_BUSY: begin
        if (!release_now) begin
          gnt_nxt = gnt;
          idx_nxt = gnt_idx;
          vld_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Pointer, hold counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_idx  <= '0;
      gnt_vld  <= 1'b0;
    end else begin
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      gnt      <= gnt_nxt;
      gnt_idx  <= idx_nxt;
      gnt_vld  <= vld_nxt;
    end
  end

endmodule
